// File: rtl/dma_way_counter_mask.sv
// rtl/dma_way_counter_mask.sv - way counter with one-hot way decode and bit-replicating mask expanders
module dma_way_counter_mask #(
    parameter int max_val_p  = 4,
    parameter int init_val_p = 0,
    parameter int num_out_p  = 4,
    parameter int expand_p   = 4,
    parameter int in_width_p = 4,
    localparam int cw_raw    = $clog2(max_val_p + 1),
    localparam int cw        = (cw_raw < 1) ? 1 : cw_raw,
    localparam int sw_raw    = $clog2(num_out_p),
    localparam int sw        = (sw_raw < 1) ? 1 : sw_raw
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           clear_i,
    input  logic                           up_i,
    output logic [cw-1:0]                  count_o,
    input  logic [sw-1:0]                  sel_i,
    output logic [num_out_p-1:0]           onehot_o,
    output logic [num_out_p*expand_p-1:0]  onehot_exp_o,
    input  logic [in_width_p-1:0]          mask_i,
    output logic [in_width_p*expand_p-1:0] mask_exp_o
);

    localparam logic [cw-1:0] max_val = cw'(max_val_p);
    localparam logic [cw-1:0] init_val = cw'(init_val_p);

    logic [cw-1:0] count_q;
    logic [cw-1:0] count_d;
    logic [cw-1:0] count_inc;

    // Increment wraps explicitly at max_val_p, which need not be a power-of-two boundary
    always_comb begin
        count_inc = count_q + cw'(1);
        if (count_q == max_val) begin
            count_inc = '0;
        end
    end

    // Next-state selection: clear wins over hold, clear with up restarts at one
    always_comb begin
        count_d = count_q;
        if (clear_i && up_i) begin
            count_d = cw'(1);
        end else if (clear_i) begin
            count_d = '0;
        end else if (up_i) begin
            count_d = count_inc;
        end
    end

    // Counter register; reset overrides any clear/up request in the same cycle
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= init_val;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

    // One-hot way decode; an index past the last way matches no output bit
    for (genvar k = 0; k < num_out_p; k++) begin : g_decode
        assign onehot_o[k] = (sel_i == sw'(k));
    end

    // Replicate every decode bit expand_p times, bit 0 into the LSB group
    for (genvar j = 0; j < num_out_p; j++) begin : g_onehot_exp
        assign onehot_exp_o[j*expand_p +: expand_p] = {expand_p{onehot_o[j]}};
    end

    // Replicate every mask bit expand_p times, bit 0 into the LSB group
    for (genvar j = 0; j < in_width_p; j++) begin : g_mask_exp
        assign mask_exp_o[j*expand_p +: expand_p] = {expand_p{mask_i[j]}};
    end

endmodule

// File: tb/tb_dma_way_counter_mask.sv
// tb/tb_dma_way_counter_mask.sv - directed bench for dma_way_counter_mask across three parameter sets
module tb_dma_way_counter_mask;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int fails = 0;

    // Instance a: all defaults
    logic        a_reset, a_clear, a_up;
    logic [2:0]  a_count;
    logic [1:0]  a_sel;
    logic [3:0]  a_onehot;
    logic [15:0] a_onehot_exp;
    logic [3:0]  a_mask;
    logic [15:0] a_mask_exp;

    dma_way_counter_mask u_dut_a (
        .clk_i        (clk),
        .reset_i      (a_reset),
        .clear_i      (a_clear),
        .up_i         (a_up),
        .count_o      (a_count),
        .sel_i        (a_sel),
        .onehot_o     (a_onehot),
        .onehot_exp_o (a_onehot_exp),
        .mask_i       (a_mask),
        .mask_exp_o   (a_mask_exp)
    );

    // Instance b: non-zero init, three ways, expand by two
    logic        b_reset, b_clear, b_up;
    logic [2:0]  b_count;
    logic [1:0]  b_sel;
    logic [2:0]  b_onehot;
    logic [5:0]  b_onehot_exp;
    logic [3:0]  b_mask;
    logic [7:0]  b_mask_exp;

    dma_way_counter_mask #(
        .max_val_p  (4),
        .init_val_p (3),
        .num_out_p  (3),
        .expand_p   (2),
        .in_width_p (4)
    ) u_dut_b (
        .clk_i        (clk),
        .reset_i      (b_reset),
        .clear_i      (b_clear),
        .up_i         (b_up),
        .count_o      (b_count),
        .sel_i        (b_sel),
        .onehot_o     (b_onehot),
        .onehot_exp_o (b_onehot_exp),
        .mask_i       (b_mask),
        .mask_exp_o   (b_mask_exp)
    );

    // Instance c: single way, no expansion, one-bit counter
    logic        c_reset, c_clear, c_up;
    logic [0:0]  c_count;
    logic [0:0]  c_sel;
    logic [0:0]  c_onehot;
    logic [0:0]  c_onehot_exp;
    logic [2:0]  c_mask;
    logic [2:0]  c_mask_exp;

    dma_way_counter_mask #(
        .max_val_p  (1),
        .init_val_p (1),
        .num_out_p  (1),
        .expand_p   (1),
        .in_width_p (3)
    ) u_dut_c (
        .clk_i        (clk),
        .reset_i      (c_reset),
        .clear_i      (c_clear),
        .up_i         (c_up),
        .count_o      (c_count),
        .sel_i        (c_sel),
        .onehot_o     (c_onehot),
        .onehot_exp_o (c_onehot_exp),
        .mask_i       (c_mask),
        .mask_exp_o   (c_mask_exp)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0]  b_exp_mask;
    logic [15:0] a_exp_mask;

    initial begin
        a_reset = 1'b1; a_clear = 1'b0; a_up = 1'b0; a_sel = 2'd2; a_mask = 4'h0;
        b_reset = 1'b1; b_clear = 1'b0; b_up = 1'b0; b_sel = 2'd0; b_mask = 4'h0;
        c_reset = 1'b1; c_clear = 1'b0; c_up = 1'b0; c_sel = 1'b0; c_mask = 3'b000;
        #1;
        // combinational paths track inputs while reset is held
        check("a_onehot_in_reset", 32'(a_onehot), 32'h4);
        check("a_onehot_exp_in_reset", 32'(a_onehot_exp), 32'h0F00);
        tick();
        check("a_reset_count", 32'(a_count), 32'd0);
        check("b_reset_count", 32'(b_count), 32'd3);
        check("c_reset_count", 32'(c_count), 32'd1);
        a_reset = 1'b0; b_reset = 1'b0; c_reset = 1'b0;

        // counter sequence with wrap
        a_up = 1'b1;
        tick(); check("a_seq_1", 32'(a_count), 32'd1);
        tick(); check("a_seq_2", 32'(a_count), 32'd2);
        tick(); check("a_seq_3", 32'(a_count), 32'd3);
        tick(); check("a_seq_4", 32'(a_count), 32'd4);
        tick(); check("a_seq_wrap", 32'(a_count), 32'd0);

        // counter controls from 3
        tick(); tick(); tick();
        check("a_ctl_at3", 32'(a_count), 32'd3);
        a_clear = 1'b1; a_up = 1'b1;
        tick(); check("a_clear_up", 32'(a_count), 32'd1);
        a_up = 1'b0;
        tick(); check("a_clear_only", 32'(a_count), 32'd0);
        a_clear = 1'b0;
        tick(); check("a_idle_1", 32'(a_count), 32'd0);
        tick(); check("a_idle_2", 32'(a_count), 32'd0);
        tick(); check("a_idle_3", 32'(a_count), 32'd0);

        // hold at a non-zero value, then reset with up/clear active
        a_up = 1'b1; tick(); tick(); a_up = 1'b0;
        tick(); check("a_hold_2", 32'(a_count), 32'd2);
        a_reset = 1'b1; a_up = 1'b1; a_clear = 1'b1;
        tick(); check("a_reset_prio", 32'(a_count), 32'd0);
        a_reset = 1'b0; a_up = 1'b0; a_clear = 1'b0;

        // instance b: count from init 3, wrap, reset priority to init
        b_up = 1'b1;
        tick(); check("b_up_4", 32'(b_count), 32'd4);
        tick(); check("b_wrap", 32'(b_count), 32'd0);
        tick(); tick();
        check("b_at_2", 32'(b_count), 32'd2);
        b_reset = 1'b1;
        tick(); check("b_reset_prio", 32'(b_count), 32'd3);
        b_reset = 1'b0; b_up = 1'b0;
        tick(); check("b_hold_after_reset", 32'(b_count), 32'd3);

        // instance c: one-bit counter wrap
        c_up = 1'b1;
        tick(); check("c_wrap", 32'(c_count), 32'd0);
        tick(); check("c_up_1", 32'(c_count), 32'd1);
        c_up = 1'b0;

        // decode and expand, default params
        a_sel = 2'd0; #1;
        check("a_onehot_s0", 32'(a_onehot), 32'h1);
        check("a_onehot_exp_s0", 32'(a_onehot_exp), 32'h000F);
        a_sel = 2'd1; #1;
        check("a_onehot_s1", 32'(a_onehot), 32'h2);
        check("a_onehot_exp_s1", 32'(a_onehot_exp), 32'h00F0);
        a_sel = 2'd2; #1;
        check("a_onehot_s2", 32'(a_onehot), 32'h4);
        check("a_onehot_exp_s2", 32'(a_onehot_exp), 32'h0F00);
        a_sel = 2'd3; #1;
        check("a_onehot_s3", 32'(a_onehot), 32'h8);
        check("a_onehot_exp_s3", 32'(a_onehot_exp), 32'hF000);

        // out-of-range and in-range decode with three ways
        b_sel = 2'd3; #1;
        check("b_onehot_oor", 32'(b_onehot), 32'h0);
        check("b_onehot_exp_oor", 32'(b_onehot_exp), 32'h0);
        b_sel = 2'd2; #1;
        check("b_onehot_s2", 32'(b_onehot), 32'h4);
        check("b_onehot_exp_s2", 32'(b_onehot_exp), 32'h30);
        b_sel = 2'd0; #1;
        check("b_onehot_s0", 32'(b_onehot), 32'h1);
        check("b_onehot_exp_s0", 32'(b_onehot_exp), 32'h03);

        // single way, no expansion
        c_sel = 1'b0; c_mask = 3'b101; #1;
        check("c_onehot_s0", 32'(c_onehot), 32'h1);
        check("c_onehot_exp_s0", 32'(c_onehot_exp), 32'h1);
        check("c_mask_exp", 32'(c_mask_exp), 32'h5);
        c_sel = 1'b1; c_mask = 3'b010; #1;
        check("c_onehot_s1", 32'(c_onehot), 32'h0);
        check("c_onehot_exp_s1", 32'(c_onehot_exp), 32'h0);
        check("c_mask_exp_2", 32'(c_mask_exp), 32'h2);

        // general mask, directed then exhaustive
        b_mask = 4'b1010; #1;
        check("b_mask_1010", 32'(b_mask_exp), 32'b11001100);
        a_mask = 4'b0110; #1;
        check("a_mask_0110", 32'(a_mask_exp), 32'h0FF0);
        for (int m = 0; m < 16; m++) begin
            b_mask = 4'(m);
            a_mask = 4'(m);
            #1;
            for (int j = 0; j < 4; j++) begin
                b_exp_mask[j*2 +: 2] = {2{b_mask[j]}};
                a_exp_mask[j*4 +: 4] = {4{a_mask[j]}};
            end
            check($sformatf("b_mask_sweep_%0d", m), 32'(b_mask_exp), 32'(b_exp_mask));
            check($sformatf("a_mask_sweep_%0d", m), 32'(a_mask_exp), 32'(a_exp_mask));
        end

        // count unaffected by combinational input activity
        check("a_count_final", 32'(a_count), 32'd0);
        check("b_count_final", 32'(b_count), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
